// File: rtl/tick_to_level_gen.sv
// Tick-to-level stretcher: each input tick becomes a HIGH_CYCLES-wide level pulse followed by a LOW_CYCLES gap.
// Optional macro TICK_LEVEL_RETRIGGER_EN: a tick during HIGH extends the pulse instead of being queued.
module tick_to_level_gen #(
   parameter int unsigned HIGH_CYCLES = 4,
   parameter int unsigned LOW_CYCLES  = 2,
   parameter int unsigned PEND_W      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   output logic              level,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int unsigned MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES);
   localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic last_c;
   logic pop_c;
   logic push_c;
   logic retrig_c;

   // Queue bookkeeping: which ticks are queued, which pending entry is replayed
   always_comb begin
      last_c   = (cnt == CNT_ONE);
      pop_c    = 1'b0;
      push_c   = 1'b0;
`ifdef TICK_LEVEL_RETRIGGER_EN
      retrig_c = tick && (state == HIGH);
`else
      retrig_c = 1'b0;
`endif
      case (state)
         HIGH: push_c = tick && !retrig_c;
         GAP: begin
            pop_c  = last_c && (pending != '0);
            // A tick at the final gap cycle with an empty queue starts the next pulse directly
            push_c = tick && !(last_c && (pending == '0));
         end
         default: begin
            pop_c  = 1'b0;
            push_c = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         level    <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tick) begin
                  state <= HIGH;
                  cnt   <= HIGH_LOAD;
                  level <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            HIGH: begin
               if (retrig_c) begin
                  cnt <= HIGH_LOAD;
               end else if (last_c) begin
                  state <= GAP;
                  cnt   <= LOW_LOAD;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            GAP: begin
               if (last_c) begin
                  if ((pending != '0) || tick) begin
                     state <= HIGH;
                     cnt   <= HIGH_LOAD;
                     level <= 1'b1;
                  end else begin
                     state <= IDLE;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               level <= 1'b0;
               busy  <= 1'b0;
            end
         endcase

         // Simultaneous push and pop leave the queue depth unchanged
         case ({push_c, pop_c})
            2'b10: begin
               if (pending != PEND_MAX) begin
                  pending <= pending + PEND_ONE;
               end else begin
                  overflow <= 1'b1;
               end
            end
            2'b01:   pending <= pending - PEND_ONE;
            default: pending <= pending;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_to_level_gen.sv
// Directed bench for tick_to_level_gen at HIGH_CYCLES=4, LOW_CYCLES=2, PEND_W=2.
// Sample index s means: value observed one time unit after posedge s-1 (i.e. "at t+s" for tick at edge t).
module tb_tick_to_level_gen;

   localparam int unsigned PEND_W = 2;

   logic              clk;
   logic              reset;
   logic              tick;
   logic              level;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   int checks;
   int failures;

   tick_to_level_gen #(
      .HIGH_CYCLES(4),
      .LOW_CYCLES (2),
      .PEND_W     (PEND_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .level   (level),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply tick for one edge, then settle just after the edge
   task automatic step(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         checks++;
         if ({level, busy, pending, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got l=%b b=%b p=%0d o=%b want all 0", i, level, busy, pending, overflow);
         end
      end
      reset = 1'b0;
      step(1'b0);
      checks++;
      if ({level, busy, pending, overflow} !== 5'b0) begin
         failures++;
         $display("FAIL reset_release got l=%b b=%b p=%0d o=%b want all 0", level, busy, pending, overflow);
      end
   endtask

   task automatic test_single();
      logic [15:0] tv;
      int s;
      tv = 16'h0001;
      for (int k = 0; k < 9; k++) begin
         step(tv[k]);
         s = k + 1;
         checks++;
         if (level !== (s <= 4)) begin
            failures++;
            $display("FAIL single_level s=%0d got %b want %b", s, level, (s <= 4));
         end
         checks++;
         if (busy !== (s <= 6)) begin
            failures++;
            $display("FAIL single_busy s=%0d got %b want %b", s, busy, (s <= 6));
         end
      end
   endtask

   task automatic test_two_ticks();
      logic [15:0] tv;
      int s;
      logic el;
      logic [PEND_W-1:0] ep;
      tv = 16'h0005;
      for (int k = 0; k < 14; k++) begin
         step(tv[k]);
         s  = k + 1;
         el = ((s >= 1) && (s <= 4)) || ((s >= 7) && (s <= 10));
         ep = ((s >= 3) && (s <= 6)) ? PEND_W'(1) : PEND_W'(0);
         checks++;
         if (level !== el) begin
            failures++;
            $display("FAIL two_level s=%0d got %b want %b", s, level, el);
         end
         checks++;
         if (pending !== ep) begin
            failures++;
            $display("FAIL two_pending s=%0d got %0d want %0d", s, pending, ep);
         end
         checks++;
         if (busy !== (s <= 12)) begin
            failures++;
            $display("FAIL two_busy s=%0d got %b want %b", s, busy, (s <= 12));
         end
      end
   endtask

   // Tick on the final gap cycle with an empty queue starts the next pulse with no extra delay
   task automatic test_back_to_back();
      logic [15:0] tv;
      int s;
      logic el;
      tv = 16'h0041;
      for (int k = 0; k < 14; k++) begin
         step(tv[k]);
         s  = k + 1;
         el = ((s >= 1) && (s <= 4)) || ((s >= 7) && (s <= 10));
         checks++;
         if (level !== el) begin
            failures++;
            $display("FAIL b2b_level s=%0d got %b want %b", s, level, el);
         end
         checks++;
         if (pending !== PEND_W'(0)) begin
            failures++;
            $display("FAIL b2b_pending s=%0d got %0d want 0", s, pending);
         end
      end
   endtask

   task automatic test_saturate();
      logic [63:0] tv;
      int s;
      int pulses;
      logic prev;
      logic el;
      logic [PEND_W-1:0] ep;
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      tv = 64'h1F;
      pulses = 0;
      prev = 1'b0;
      for (int k = 0; k < 28; k++) begin
         step(tv[k]);
         s  = k + 1;
         el = (s <= 22) && (((s - 1) % 6) < 4);
         if (s == 1)       ep = PEND_W'(0);
         else if (s <= 3)  ep = PEND_W'(s - 1);
         else if (s <= 6)  ep = PEND_W'(3);
         else if (s <= 12) ep = PEND_W'(2);
         else if (s <= 18) ep = PEND_W'(1);
         else              ep = PEND_W'(0);
         if (level && !prev) pulses++;
         prev = level;
         checks++;
         if (level !== el) begin
            failures++;
            $display("FAIL sat_level s=%0d got %b want %b", s, level, el);
         end
         checks++;
         if (pending !== ep) begin
            failures++;
            $display("FAIL sat_pending s=%0d got %0d want %0d", s, pending, ep);
         end
         checks++;
         if (overflow !== (s >= 5)) begin
            failures++;
            $display("FAIL sat_overflow s=%0d got %b want %b", s, overflow, (s >= 5));
         end
         checks++;
         if (busy !== (s <= 24)) begin
            failures++;
            $display("FAIL sat_busy s=%0d got %b want %b", s, busy, (s <= 24));
         end
      end
      checks++;
      if (pulses != 4) begin
         failures++;
         $display("FAIL sat_pulse_count got %0d want 4", pulses);
      end
   endtask

   task automatic test_retrigger();
      logic [15:0] tv;
      int s;
      tv = 16'h0005;
      for (int k = 0; k < 12; k++) begin
         step(tv[k]);
         s = k + 1;
         checks++;
         if (level !== (s <= 6)) begin
            failures++;
            $display("FAIL retrig_level s=%0d got %b want %b", s, level, (s <= 6));
         end
         checks++;
         if (pending !== PEND_W'(0)) begin
            failures++;
            $display("FAIL retrig_pending s=%0d got %0d want 0", s, pending);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      checks++;
      if ((level !== 1'b1) || (pending !== PEND_W'(2))) begin
         failures++;
         $display("FAIL mid_pre got l=%b p=%0d want l=1 p=2", level, pending);
      end
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      checks++;
      if ({level, busy, pending, overflow} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset got l=%b b=%b p=%0d o=%b want all 0", level, busy, pending, overflow);
      end
      for (int i = 0; i < 15; i++) begin
         step(1'b0);
         checks++;
         if ({level, busy, pending} !== 4'b0) begin
            failures++;
            $display("FAIL mid_quiet cyc=%0d got l=%b b=%b p=%0d want 0", i, level, busy, pending);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      tick     = 1'b0;
      test_reset();
      test_single();
`ifdef TICK_LEVEL_RETRIGGER_EN
      test_retrigger();
`else
      test_two_ticks();
      test_back_to_back();
      test_saturate();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
